// File: rtl/sensor_scan_pkg.sv
// Shared definitions for the sensor scan scheduler: FSM state encoding,
// ADC channel indices and the averaging constants used when the
// SENSOR_AVG_EN build option is enabled.
package sensor_scan_pkg;

    // State encoding, kept as plain constants so other tools can decode it.
    localparam logic [2:0] ST_IDLE        = 3'd0;
    localparam logic [2:0] ST_START       = 3'd1;
    localparam logic [2:0] ST_CONVERT     = 3'd2;
    localparam logic [2:0] ST_STORE       = 3'd3;
    localparam logic [2:0] ST_DONE        = 3'd4;
    localparam logic [2:0] ST_WAIT_PERIOD = 3'd5;

    typedef enum logic [2:0] {
        IDLE        = ST_IDLE,
        START       = ST_START,
        CONVERT     = ST_CONVERT,
        STORE       = ST_STORE,
        DONE        = ST_DONE,
        WAIT_PERIOD = ST_WAIT_PERIOD
    } state_t;

    typedef logic [1:0] ch_t;

    localparam ch_t CH_REF = 2'd0;
    localparam ch_t CH_1   = 2'd1;
    localparam ch_t CH_2   = 2'd2;
    localparam ch_t CH_3   = 2'd3;
    localparam int  NUM_CH = 4;

    // Averaging: AVG_SAMPLES conversions per channel, mean = sum >> AVG_SHIFT.
    localparam int AVG_SAMPLES = 4;
    localparam int AVG_SHIFT   = 2;

endpackage

// File: rtl/sensor_scan_scheduler_if.sv
// ADC handshake bundle between the scan scheduler and the shared ADC.
//   adc_start : one-cycle conversion request (scheduler -> ADC)
//   adc_ch    : channel select, 0 = ref, 1..3 = line sensors (scheduler -> ADC)
//   adc_done  : one-cycle conversion-complete strobe (ADC -> scheduler)
//   adc_data  : sample, valid only while adc_done is high (ADC -> scheduler)
// master = scheduler side, slave = ADC side.
interface sensor_scan_scheduler_if #(
    parameter int DATA_W = 12
);
    logic              adc_start;
    logic [1:0]        adc_ch;
    logic              adc_done;
    logic [DATA_W-1:0] adc_data;

    modport master (output adc_start, adc_ch, input adc_done, adc_data);
    modport slave  (input adc_start, adc_ch, output adc_done, adc_data);
endinterface

// File: rtl/scan_period_timer.sv
// Saturating up-counter used for both the scan period and the conversion
// timeout. restart_i loads zero; otherwise the count climbs to MAX-1 and
// stays there, so expired_o holds until the next restart.
//   clk, rst  : clock, synchronous active-high reset
//   restart_i : load zero on the next edge
//   expired_o : count has reached MAX-1
module scan_period_timer #(
    parameter int MAX = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic restart_i,
    output logic expired_o
);
    localparam int              CNT_W = $clog2(MAX);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX - 1);

    logic [CNT_W-1:0] count_q, count_d;

    // NOTE: combinational blocks use blocking '=' and assign every output a
    // default first, so no path through the block can infer a latch.
    always_comb begin
        count_d = count_q;
        if (restart_i) begin
            count_d = '0;
        end else if (count_q < LAST) begin
            count_d = count_q + 1'b1;
        end
    end

    // NOTE: clocked state uses non-blocking '<=' so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q >= LAST);
endmodule

// File: rtl/sensor_scan_scheduler.sv
// Time-multiplexes one ADC across the reference sensor and three line
// sensors. A scan (ref, 1, 2, 3) starts every SCAN_PERIOD cycles; the four
// samples are collected into shadow registers and published together in
// DONE, with a one-cycle ready_o pulse for the relay FSM.
//   clk, rst          : clock, synchronous active-high reset
//   enable_i          : scanning allowed while high
//   adc               : ADC handshake (master side)
//   sen_*_o           : published samples, updated atomically
//   ready_o           : one-cycle pulse when a scan is published
//   valid_o           : set once any scan has been published
//   timeout_o         : sticky conversion-timeout flag
// Build option: SENSOR_AVG_EN converts each channel AVG_SAMPLES times and
// stores the truncated mean.
module sensor_scan_scheduler
    import sensor_scan_pkg::*;
#(
    parameter int DATA_W      = 12,
    parameter int SCAN_PERIOD = 800000,
    parameter int TIMEOUT     = 4096
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable_i,
    sensor_scan_scheduler_if.master adc,
    output logic [DATA_W-1:0]       sen_ref_o,
    output logic [DATA_W-1:0]       sen_1_o,
    output logic [DATA_W-1:0]       sen_2_o,
    output logic [DATA_W-1:0]       sen_3_o,
    output logic                    ready_o,
    output logic                    valid_o,
    output logic                    timeout_o
);
    state_t            state_q, state_d;
    ch_t               ch_q, ch_d;
    logic [DATA_W-1:0] shadow_q [NUM_CH];
    logic [DATA_W-1:0] shadow_d [NUM_CH];
    logic [DATA_W-1:0] sen_q    [NUM_CH];
    logic [DATA_W-1:0] sen_d    [NUM_CH];
    logic              valid_q, valid_d;
    logic              timeout_q, timeout_d;

    logic period_restart, period_expired;
    logic conv_restart, conv_expired;

`ifdef SENSOR_AVG_EN
    logic [1:0]        sub_q, sub_d;
    logic [DATA_W+1:0] acc_q, acc_d;
    logic [DATA_W+1:0] acc_sum;
`endif

    // The period restarts only on entry to a channel-0 START, not on the
    // repeated STARTs inside a scan.
    assign period_restart = (state_d == START) &&
                            (state_q inside {IDLE, DONE, WAIT_PERIOD});
    // The conversion timer counts CONVERT cycles only.
    assign conv_restart   = (state_q != CONVERT);

    scan_period_timer #(.MAX(SCAN_PERIOD)) u_period_timer (
        .clk       (clk),
        .rst       (rst),
        .restart_i (period_restart),
        .expired_o (period_expired)
    );

    scan_period_timer #(.MAX(TIMEOUT)) u_conv_timer (
        .clk       (clk),
        .rst       (rst),
        .restart_i (conv_restart),
        .expired_o (conv_expired)
    );

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        shadow_d  = shadow_q;
        sen_d     = sen_q;
        valid_d   = valid_q;
        timeout_d = timeout_q;
`ifdef SENSOR_AVG_EN
        sub_d     = sub_q;
        acc_d     = acc_q;
        acc_sum   = acc_q + (DATA_W+2)'(adc.adc_data);
`endif

        case (state_q)
            IDLE: begin
                if (enable_i) begin
                    state_d = START;
                    ch_d    = CH_REF;
                end
            end
            START: state_d = CONVERT;
            CONVERT: begin
                // A finished conversion wins over a timeout in the same cycle.
                if (adc.adc_done) begin
`ifdef SENSOR_AVG_EN
                    if (sub_q == 2'(AVG_SAMPLES - 1)) begin
                        shadow_d[ch_q] = DATA_W'(acc_sum >> AVG_SHIFT);
                        state_d        = enable_i ? STORE : IDLE;
                    end else begin
                        sub_d   = sub_q + 1'b1;
                        acc_d   = acc_sum;
                        state_d = enable_i ? START : IDLE;
                    end
`else
                    shadow_d[ch_q] = adc.adc_data;
                    state_d        = enable_i ? STORE : IDLE;
`endif
                end else if (conv_expired) begin
                    // Abort: the partial scan is never published.
                    timeout_d = 1'b1;
                    state_d   = WAIT_PERIOD;
                end
            end
            STORE: begin
                if (!enable_i) begin
                    state_d = IDLE;
                end else if (ch_q != CH_3) begin
                    ch_d    = ch_q + 1'b1;
                    state_d = START;
                end else begin
                    // Load outputs on the edge into DONE so they are visible
                    // in the same cycle as ready_o.
                    sen_d   = shadow_q;
                    valid_d = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                // An overrunning scan starts the next one straight away.
                if (enable_i && period_expired) begin
                    state_d = START;
                    ch_d    = CH_REF;
                end else begin
                    state_d = WAIT_PERIOD;
                end
            end
            WAIT_PERIOD: begin
                if (!enable_i) begin
                    state_d = IDLE;
                end else if (period_expired) begin
                    state_d = START;
                    ch_d    = CH_REF;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef SENSOR_AVG_EN
        // Leaving the START/CONVERT loop always starts the next channel clean.
        if (!(state_d inside {START, CONVERT})) begin
            sub_d = '0;
            acc_d = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ch_q      <= CH_REF;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            // NOTE: the shadow and output arrays are reset as well; they are
            // only four words each and published values must read 0 after reset.
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_q[i] <= '0;
                sen_q[i]    <= '0;
            end
`ifdef SENSOR_AVG_EN
            sub_q     <= '0;
            acc_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            shadow_q  <= shadow_d;
            sen_q     <= sen_d;
`ifdef SENSOR_AVG_EN
            sub_q     <= sub_d;
            acc_q     <= acc_d;
`endif
        end
    end

    assign adc.adc_start = (state_q == START);
    assign adc.adc_ch    = ch_q;
    assign ready_o       = (state_q == DONE);
    assign valid_o       = valid_q;
    assign timeout_o     = timeout_q;
    assign sen_ref_o     = sen_q[CH_REF];
    assign sen_1_o       = sen_q[CH_1];
    assign sen_2_o       = sen_q[CH_2];
    assign sen_3_o       = sen_q[CH_3];
endmodule

// File: tb/tb_sensor_scan_scheduler.sv
// Self-checking bench for sensor_scan_scheduler. A behavioural ADC answers
// each start after adc_delay cycles; a monitor logs start/ready events and
// the expected published values from the bench's own ADC answers.
module tb_sensor_scan_scheduler;
    localparam int DATA_W      = 12;
    localparam int SCAN_PERIOD = 64;
    localparam int TIMEOUT     = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              enable_i = 1'b0;
    logic [DATA_W-1:0] sen_ref_o, sen_1_o, sen_2_o, sen_3_o;
    logic              ready_o, valid_o, timeout_o;

    sensor_scan_scheduler_if #(.DATA_W(DATA_W)) adc_bus ();

    sensor_scan_scheduler #(
        .DATA_W(DATA_W), .SCAN_PERIOD(SCAN_PERIOD), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .enable_i(enable_i), .adc(adc_bus),
        .sen_ref_o(sen_ref_o), .sen_1_o(sen_1_o), .sen_2_o(sen_2_o), .sen_3_o(sen_3_o),
        .ready_o(ready_o), .valid_o(valid_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- behavioural ADC ----------------
    int                adc_delay = 5;
    int                mute_ch   = -1;
    bit                rand_mode = 1'b0;
    logic [DATA_W-1:0] dat [4][4];
    int                sub_idx [4];
    logic [DATA_W-1:0] last_ans [4];
    int                pend = -1;
    int                pend_ch = 0;
    int                ans_cnt = 0;

    initial begin
        adc_bus.adc_done = 1'b0;
        adc_bus.adc_data = '0;
        for (int c = 0; c < 4; c++) begin
            sub_idx[c] = 0; last_ans[c] = '0;
            for (int s = 0; s < 4; s++) dat[c][s] = '0;
        end
        forever begin
            @(negedge clk);
            adc_bus.adc_done = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    if (rand_mode) dat[pend_ch][sub_idx[pend_ch]] = DATA_W'($urandom);
                    adc_bus.adc_data  = dat[pend_ch][sub_idx[pend_ch]];
                    last_ans[pend_ch] = adc_bus.adc_data;
                    sub_idx[pend_ch]  = (sub_idx[pend_ch] + 1) % 4;
                    adc_bus.adc_done  = 1'b1;
                    ans_cnt++;
                    pend = -1;
                end
            end
            if (adc_bus.adc_start === 1'b1) begin
                pend_ch = int'(adc_bus.adc_ch);
                pend    = (pend_ch == mute_ch) ? -1 : adc_delay;
            end
        end
    end

    // Expected published value of one channel for the scan just completed.
    function automatic logic [DATA_W-1:0] exp_val(input int ch);
`ifdef SENSOR_AVG_EN
        int sum = 0;
        for (int s = 0; s < 4; s++) sum += int'(dat[ch][s]);
        return DATA_W'(sum / 4);
`else
        return last_ans[ch];
`endif
    endfunction

    // ---------------- monitor ----------------
    int                  start_cyc [$];
    int                  start_ch  [$];
    int                  ready_cyc [$];
    logic [4*DATA_W-1:0] pub_got [$];
    logic [4*DATA_W-1:0] pub_exp [$];
    logic [4*DATA_W-1:0] model_pub = '0;
    logic [4*DATA_W-1:0] prev_pub  = '0;
    int                  change_bad = 0;
    int                  to_rise = -1;
    logic                to_prev = 1'b0;
    logic                rst_prev = 1'b1;

    initial begin
        logic [4*DATA_W-1:0] cur;
        forever begin
            @(negedge clk);
            #1;
            cur = {sen_ref_o, sen_1_o, sen_2_o, sen_3_o};
            if (adc_bus.adc_start === 1'b1) begin
                start_cyc.push_back(cyc);
                start_ch.push_back(int'(adc_bus.adc_ch));
            end
            if (ready_o === 1'b1) begin
                ready_cyc.push_back(cyc);
                pub_got.push_back(cur);
                model_pub = {exp_val(0), exp_val(1), exp_val(2), exp_val(3)};
                pub_exp.push_back(model_pub);
            end
            if (!rst && !rst_prev && cur !== prev_pub && ready_o !== 1'b1) change_bad++;
            if (timeout_o === 1'b1 && !to_prev) to_rise = cyc;
            to_prev  = timeout_o;
            prev_pub = cur;
            rst_prev = rst;
        end
    end

    task automatic clear_logs();
        start_cyc.delete(); start_ch.delete(); ready_cyc.delete();
        pub_got.delete(); pub_exp.delete();
        change_bad = 0; ans_cnt = 0;
    endtask

    task automatic wait_start_ch(input int ch, input int bound, output int idx);
        idx = -1;
        for (int i = 0; i < bound && idx < 0; i++) begin
            @(negedge clk); #2;
            foreach (start_ch[j]) if (start_ch[j] == ch && idx < 0) idx = j;
        end
    endtask

    task automatic wait_ready(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            @(negedge clk); #2;
            if (ready_cyc.size() > 0) ok = 1'b1;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; enable_i = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_checks++; if ({sen_ref_o, sen_1_o, sen_2_o, sen_3_o} !== '0) begin n_fail++; $display("FAIL reset_samples: got %h want 0", {sen_ref_o, sen_1_o, sen_2_o, sen_3_o}); end
        n_checks++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", ready_o); end
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid_o); end
        n_checks++; if (timeout_o !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b want 0", timeout_o); end
        n_checks++; if (adc_bus.adc_start !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %b want 0", adc_bus.adc_start); end
        n_checks++; if (adc_bus.adc_ch !== 2'd0) begin n_fail++; $display("FAIL reset_ch: got %0d want 0", adc_bus.adc_ch); end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_scan();
        bit ok;
        clear_logs();
        rand_mode = 1'b0; adc_delay = 5;
        for (int c = 0; c < 4; c++) for (int s = 0; s < 4; s++) dat[c][s] = DATA_W'((c + 1) * 100);
        enable_i = 1'b1;
        wait_ready(200, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL scan_ready_seen: got none want pulse within 200 cycles"); end
        repeat (5) @(negedge clk);
        #2;
        n_checks++; if (start_cyc.size() !== 4) begin n_fail++; $display("FAIL scan_start_count: got %0d want 4", start_cyc.size()); end
        for (int i = 0; i < 4 && i < start_ch.size(); i++) begin
            n_checks++; if (start_ch[i] !== i) begin n_fail++; $display("FAIL scan_ch_order[%0d]: got %0d want %0d", i, start_ch[i], i); end
        end
        for (int i = 0; i + 1 < start_cyc.size(); i++) begin
            // done at start+delay, next start two cycles after done
            n_checks++; if (start_cyc[i+1] - start_cyc[i] !== adc_delay + 2) begin n_fail++; $display("FAIL scan_start_gap[%0d]: got %0d want %0d", i, start_cyc[i+1] - start_cyc[i], adc_delay + 2); end
        end
        n_checks++; if (ready_cyc.size() !== 1) begin n_fail++; $display("FAIL scan_ready_pulses: got %0d want 1", ready_cyc.size()); end
        if (ready_cyc.size() > 0 && start_cyc.size() > 0) begin
            n_checks++; if (ready_cyc[0] - start_cyc[0] !== 4 * (adc_delay + 2)) begin n_fail++; $display("FAIL scan_latency: got %0d want %0d", ready_cyc[0] - start_cyc[0], 4 * (adc_delay + 2)); end
        end
        n_checks++; if ({sen_ref_o, sen_1_o, sen_2_o, sen_3_o} !== {12'd100, 12'd200, 12'd300, 12'd400}) begin n_fail++; $display("FAIL scan_values: got %0d %0d %0d %0d want 100 200 300 400", sen_ref_o, sen_1_o, sen_2_o, sen_3_o); end
        n_checks++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL scan_valid: got %b want 1", valid_o); end
        enable_i = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_period();
        int ch0 [$];
        clear_logs();
        rand_mode = 1'b1; adc_delay = $urandom_range(2, 9);
        enable_i = 1'b1;
        repeat (300) @(negedge clk);
        enable_i = 1'b0;
        repeat (20) @(negedge clk);
        foreach (start_ch[i]) if (start_ch[i] == 0) ch0.push_back(start_cyc[i]);
        n_checks++; if (ch0.size() < 4) begin n_fail++; $display("FAIL period_scans: got %0d want >=4", ch0.size()); end
        for (int i = 0; i + 1 < ch0.size(); i++) begin
            n_checks++; if (ch0[i+1] - ch0[i] !== SCAN_PERIOD) begin n_fail++; $display("FAIL period_gap[%0d]: got %0d want %0d", i, ch0[i+1] - ch0[i], SCAN_PERIOD); end
        end
        n_checks++; if (ready_cyc.size() < 4) begin n_fail++; $display("FAIL period_ready_count: got %0d want >=4", ready_cyc.size()); end
        foreach (pub_got[i]) begin
            n_checks++; if (pub_got[i] !== pub_exp[i]) begin n_fail++; $display("FAIL period_values[%0d]: got %h want %h", i, pub_got[i], pub_exp[i]); end
        end
        n_checks++; if (change_bad !== 0) begin n_fail++; $display("FAIL period_stable: got %0d changes outside DONE want 0", change_bad); end
    endtask

    task automatic test_enable_drop();
        int idx;
        logic [4*DATA_W-1:0] exp_prev;
        clear_logs();
        rand_mode = 1'b1; adc_delay = 5;
        exp_prev = model_pub;
        enable_i = 1'b1;
        wait_start_ch(1, 100, idx);
        n_checks++; if (idx < 0) begin n_fail++; $display("FAIL drop_ch1_start: got none want channel-1 start"); end
        @(negedge clk);   // now in CONVERT on channel 1
        enable_i = 1'b0;
        repeat (40) @(negedge clk);
        #2;
        n_checks++; if (start_cyc.size() !== 2) begin n_fail++; $display("FAIL drop_starts: got %0d want 2", start_cyc.size()); end
        n_checks++; if (ans_cnt !== 2) begin n_fail++; $display("FAIL drop_conversions: got %0d want 2", ans_cnt); end
        n_checks++; if (ready_cyc.size() !== 0) begin n_fail++; $display("FAIL drop_ready: got %0d want 0", ready_cyc.size()); end
        n_checks++; if ({sen_ref_o, sen_1_o, sen_2_o, sen_3_o} !== exp_prev) begin n_fail++; $display("FAIL drop_outputs: got %h want %h", {sen_ref_o, sen_1_o, sen_2_o, sen_3_o}, exp_prev); end
        n_checks++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL drop_valid: got %b want 1", valid_o); end
    endtask

    task automatic test_timeout();
        int idx2;
        bit ok;
        logic [4*DATA_W-1:0] exp_prev;
        clear_logs();
        rand_mode = 1'b1; adc_delay = 5; mute_ch = 2;
        exp_prev = model_pub;
        enable_i = 1'b1;
        wait_start_ch(2, 100, idx2);
        n_checks++; if (idx2 < 0) begin n_fail++; $display("FAIL to_ch2_start: got none want channel-2 start"); end
        for (int i = 0; i < 60 && to_rise < 0; i++) @(negedge clk);
        #2;
        n_checks++; if (to_rise < 0) begin n_fail++; $display("FAIL to_flag_seen: got none want rise within 60 cycles"); end
        if (idx2 >= 0 && to_rise >= 0) begin
            // TIMEOUT CONVERT cycles after START, flag visible one cycle later
            n_checks++; if (to_rise - start_cyc[idx2] !== TIMEOUT + 1) begin n_fail++; $display("FAIL to_latency: got %0d want %0d", to_rise - start_cyc[idx2], TIMEOUT + 1); end
        end
        n_checks++; if (ready_cyc.size() !== 0) begin n_fail++; $display("FAIL to_ready: got %0d want 0", ready_cyc.size()); end
        n_checks++; if ({sen_ref_o, sen_1_o, sen_2_o, sen_3_o} !== exp_prev) begin n_fail++; $display("FAIL to_outputs: got %h want %h", {sen_ref_o, sen_1_o, sen_2_o, sen_3_o}, exp_prev); end
        mute_ch = -1;
        wait_ready(200, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL to_next_scan: got no ready want one within 200 cycles"); end
        if (idx2 >= 0 && start_ch.size() > idx2 + 1) begin
            n_checks++; if (start_ch[idx2+1] !== 0) begin n_fail++; $display("FAIL to_restart_ch: got %0d want 0", start_ch[idx2+1]); end
            n_checks++; if (start_cyc[idx2+1] - start_cyc[0] !== SCAN_PERIOD) begin n_fail++; $display("FAIL to_restart_time: got %0d want %0d", start_cyc[idx2+1] - start_cyc[0], SCAN_PERIOD); end
        end
        if (ok) begin
            n_checks++; if (pub_got[0] !== pub_exp[0]) begin n_fail++; $display("FAIL to_next_values: got %h want %h", pub_got[0], pub_exp[0]); end
        end
        n_checks++; if (timeout_o !== 1'b1) begin n_fail++; $display("FAIL to_sticky: got %b want 1", timeout_o); end
        n_checks++; if (change_bad !== 0) begin n_fail++; $display("FAIL to_stable: got %0d changes outside DONE want 0", change_bad); end
        enable_i = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset_mid_scan();
        int idx;
        clear_logs();
        rand_mode = 1'b1; adc_delay = 5;
        enable_i = 1'b1;
        wait_start_ch(2, 100, idx);
        n_checks++; if (idx < 0) begin n_fail++; $display("FAIL rstmid_ch2_start: got none want channel-2 start"); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        n_checks++; if ({sen_ref_o, sen_1_o, sen_2_o, sen_3_o} !== '0) begin n_fail++; $display("FAIL rstmid_samples: got %h want 0", {sen_ref_o, sen_1_o, sen_2_o, sen_3_o}); end
        n_checks++; if ({ready_o, valid_o, timeout_o} !== 3'b000) begin n_fail++; $display("FAIL rstmid_flags: got %b want 000", {ready_o, valid_o, timeout_o}); end
        n_checks++; if ({adc_bus.adc_start, adc_bus.adc_ch} !== 3'b000) begin n_fail++; $display("FAIL rstmid_adc: got %b want 000", {adc_bus.adc_start, adc_bus.adc_ch}); end
        rst = 1'b0; enable_i = 1'b0;
        repeat (10) @(negedge clk);
    endtask

`ifdef SENSOR_AVG_EN
    task automatic test_avg();
        bit ok;
        int n_before;
        clear_logs();
        rand_mode = 1'b0; adc_delay = 4;
        for (int c = 0; c < 4; c++) begin
            sub_idx[c] = 0;
            for (int s = 0; s < 4; s++) dat[c][s] = DATA_W'($urandom);
        end
        dat[1][0] = 12'd10; dat[1][1] = 12'd11; dat[1][2] = 12'd12; dat[1][3] = 12'd14;
        enable_i = 1'b1;
        wait_ready(600, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL avg_ready_seen: got none want pulse within 600 cycles"); end
        #1;
        n_before = 0;
        foreach (start_cyc[i]) if (ok && start_cyc[i] < ready_cyc[0]) n_before++;
        n_checks++; if (n_before !== 16) begin n_fail++; $display("FAIL avg_start_count: got %0d want 16", n_before); end
        for (int i = 0; i < 16 && i < start_ch.size(); i++) begin
            n_checks++; if (start_ch[i] !== i / 4) begin n_fail++; $display("FAIL avg_ch_order[%0d]: got %0d want %0d", i, start_ch[i], i / 4); end
        end
        n_checks++; if (sen_1_o !== 12'd11) begin n_fail++; $display("FAIL avg_sen1: got %0d want 11", sen_1_o); end
        if (ok) begin
            n_checks++; if (pub_got[0] !== pub_exp[0]) begin n_fail++; $display("FAIL avg_values: got %h want %h", pub_got[0], pub_exp[0]); end
        end
        n_checks++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL avg_valid: got %b want 1", valid_o); end
        enable_i = 1'b0;
        repeat (20) @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
`ifdef SENSOR_AVG_EN
        test_avg();
`else
        test_single_scan();
        test_period();
        test_enable_drop();
        test_timeout();
        test_reset_mid_scan();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t want finished", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
